loa_accumulator: RTL and testbench



---
 rtl/loa_acc_pkg.sv | 15 +
 rtl/loa_adder.sv | 25 ++
 rtl/loa_accumulator.sv | 134 +++++++++++++
 tb/tb_loa_accumulator.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loa_acc_pkg.sv
// Shared types and sizing helpers for the lower-part-OR accumulator.
package loa_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Term counter must be able to represent NUM_TERMS itself.
  function automatic int cnt_w(input int num_terms);
    return $clog2(num_terms + 1);
  endfunction

endpackage

// File: rtl/loa_adder.sv
// Combinational lower-part-OR approximate adder; sum_o[ADDER_LENGTH] is the carry-out.
module loa_adder #(
  parameter int ADDER_LENGTH   = 32,
  parameter int IMPRECISE_PART = 8
) (
  input  logic [ADDER_LENGTH-1:0] a_i,
  input  logic [ADDER_LENGTH-1:0] b_i,
  output logic [ADDER_LENGTH:0]   sum_o
);

  localparam int UW = ADDER_LENGTH - IMPRECISE_PART;

  logic [IMPRECISE_PART-1:0] low;
  logic                      carry;
  logic [UW:0]               upper;

  assign low   = a_i[IMPRECISE_PART-1:0] | b_i[IMPRECISE_PART-1:0];
  // The only carry into the exact part comes from the top imprecise bit pair.
  assign carry = a_i[IMPRECISE_PART-1] & b_i[IMPRECISE_PART-1];
  assign upper = {1'b0, a_i[ADDER_LENGTH-1:IMPRECISE_PART]}
               + {1'b0, b_i[ADDER_LENGTH-1:IMPRECISE_PART]}
               + {{UW{1'b0}}, carry};
  assign sum_o = {upper, low};

endmodule

// File: rtl/loa_accumulator.sv
// Folds NUM_TERMS operands into one LOA partial sum with a registered valid/ready output.
// Build option: define LOA_ACC_SAT_EN to saturate the accumulator on carry-out instead of wrapping.
module loa_accumulator
  import loa_acc_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int IMPRECISE_PART = 8,
  parameter int NUM_TERMS      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc_clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int                CNT_W = cnt_w(NUM_TERMS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_TERMS);

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sticky_q, sticky_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic                   out_ovf_q, out_ovf_d;

  logic [ACC_WIDTH-1:0]   operand;
  logic [ACC_WIDTH:0]     loa_sum;
  logic                   carry;
  logic [ACC_WIDTH-1:0]   acc_step;
  logic                   accept;
  logic [ACC_WIDTH-1:0]   term_acc;
  logic                   term_sticky;
  logic [CNT_W-1:0]       term_cnt;

  assign operand = ACC_WIDTH'(in_data);

  loa_adder #(
    .ADDER_LENGTH   (ACC_WIDTH),
    .IMPRECISE_PART (IMPRECISE_PART)
  ) u_loa_adder (
    .a_i   (acc_q),
    .b_i   (operand),
    .sum_o (loa_sum)
  );

  assign carry = loa_sum[ACC_WIDTH];

`ifdef LOA_ACC_SAT_EN
  assign acc_step = carry ? {ACC_WIDTH{1'b1}} : loa_sum[ACC_WIDTH-1:0];
`else
  assign acc_step = loa_sum[ACC_WIDTH-1:0];
`endif

  assign in_ready  = !acc_clr && (state_q != HOLD || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    // First term of a group (from IDLE or reloading out of HOLD) loads exactly.
    term_acc    = operand;
    term_sticky = 1'b0;
    term_cnt    = CNT_W'(1);
    if (state_q == ACCUM) begin
      term_acc    = acc_step;
      term_sticky = sticky_q | carry;
      term_cnt    = cnt_q + CNT_W'(1);
    end

    if (acc_clr && state_q != HOLD) begin
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
      state_d  = IDLE;
    end else if (accept) begin
      acc_d    = term_acc;
      sticky_d = term_sticky;
      if (term_cnt == LAST) begin
        cnt_d       = '0;
        out_sum_d   = term_acc;
        out_ovf_d   = term_sticky;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end else begin
        cnt_d       = term_cnt;
        out_valid_d = 1'b0;
        state_d     = ACCUM;
      end
    end else if (state_q == HOLD && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_loa_accumulator.sv
// Directed bench for loa_accumulator: scoreboarded results plus a narrow overflow instance.
module tb_loa_accumulator;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int IP = 8;
  localparam int NT = 4;
  localparam int BW = 17;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, acc_clr, in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
  logic [DW-1:0] in_data;
  logic [AW-1:0] out_sum;

  logic          b_acc_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_busy;
  logic [DW-1:0] b_in_data;
  logic [BW-1:0] b_out_sum;

  loa_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .IMPRECISE_PART(IP), .NUM_TERMS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .busy(busy));

  loa_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(BW), .IMPRECISE_PART(IP), .NUM_TERMS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .acc_clr(b_acc_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_ovf(b_out_ovf), .busy(b_busy));

  typedef struct {
    logic [AW-1:0] sum;
    logic          ovf;
  } exp_t;

  exp_t               sb_q[$];
  exp_t               mon_e;
  int                 checks = 0;
  int                 errors = 0;
  longint unsigned    m_acc;
  int                 m_cnt;
  logic               m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference LOA on wide integers; the bit above the operand width is the carry-out.
  function automatic longint unsigned loa_m(input longint unsigned a, input longint unsigned b);
    longint unsigned lo_mask, low, c, up;
    lo_mask = (64'd1 << IP) - 1;
    low     = (a | b) & lo_mask;
    c       = (a >> (IP - 1)) & (b >> (IP - 1)) & 64'd1;
    up      = (a >> IP) + (b >> IP) + c;
    return (up << IP) | low;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d);
    longint unsigned r;
    if (m_cnt == 0) begin
      m_acc = longint'(d);
      m_ovf = 1'b0;
    end else begin
      r = loa_m(m_acc, longint'(d));
      if (((r >> AW) & 64'd1) != 0) m_ovf = 1'b1;
      m_acc = r & ((64'd1 << AW) - 1);
    end
    m_cnt++;
    if (m_cnt == NT) begin
      sb_q.push_back('{AW'(m_acc), m_ovf});
      m_cnt = 0;
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("in_ready_wait", in_ready, 1'b1);
    model_accept(d);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output observed=%0h expected=none", out_sum);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_out_sum", out_sum, mon_e.sum);
        check("sb_out_ovf", out_ovf, mon_e.ovf);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; acc_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_acc_clr = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lower bits OR together: exact sum would be 0x200
    send(16'h000F); send(16'h00F0); send(16'h0001);
    check("t1_no_early_valid", out_valid, 1'b0);
    send(16'h0100);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_latency_valid", out_valid, 1'b1);
    check("t1_sum", out_sum, 32'h1FF);
    check("t1_ovf", out_ovf, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_back_idle_valid", out_valid, 1'b0);
    check("t1_back_idle_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Carry out of bit 7 into the exact part
    send(16'h0080); send(16'h0080); send(16'h0000); send(16'h0000);
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_sum", out_sum, 32'h180);
    @(posedge clk); #1;

    // Backpressure, then handshake and accept in the same cycle
    out_ready = 1'b0;
    send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_sum", out_sum, 32'h7);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(16'h0005);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drop_valid", out_valid, 1'b0);
    check("bp_accum_busy", busy, 1'b1);
    @(posedge clk); #1;
    send(16'h0010); send(16'h0020); send(16'h0040);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_sum", out_sum, 32'h75);
    @(posedge clk); #1;

    // acc_clr after two terms discards the partial group
    send(16'h0100); send(16'h0200);
    in_valid = 1'b1; in_data = 16'h0400; acc_clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    acc_clr = 1'b0; in_valid = 1'b0; m_cnt = 0;
    @(negedge clk);
    check("clr_busy", busy, 1'b0);
    @(posedge clk); #1;
    send(16'h0001); send(16'h0002); send(16'h0004); send(16'h0008);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_sum", out_sum, 32'hF);
    @(posedge clk); #1;

    // Asynchronous reset mid-ACCUM
    send(16'h0030); send(16'h0040);
    in_valid = 1'b0;
    @(negedge clk);
    check("ra_busy_before", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("ra_busy", busy, 1'b0);
    check("ra_out_valid", out_valid, 1'b0);
    m_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-HOLD
    out_ready = 1'b0;
    send(16'h0001); send(16'h0001); send(16'h0001); send(16'h0001);
    in_valid = 1'b0;
    @(negedge clk);
    check("rh_valid_before", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rh_out_valid", out_valid, 1'b0);
    check("rh_busy", busy, 1'b0);
    check("rh_out_sum", out_sum, 32'h0);
    sb_q.delete();
    m_cnt = 0;
    @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
    @(posedge clk); #1;
    send(16'h0011); send(16'h0022); send(16'h0044); send(16'h0088);
    in_valid = 1'b0;
    @(negedge clk);
    check("rh_fresh_sum", out_sum, 32'hFF);
    @(posedge clk); #1;

    // Narrow accumulator: carry-out wraps or saturates
    b_in_valid = 1'b1; b_in_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b_in_ready", b_in_ready, 1'b1);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    @(negedge clk);
    check("b_out_valid", b_out_valid, 1'b1);
`ifdef LOA_ACC_SAT_EN
    check("b_out_sum", b_out_sum, 17'h1FFFF);
`else
    check("b_out_sum", b_out_sum, 17'h0FFFF);
`endif
    check("b_out_ovf", b_out_ovf, 1'b1);
    @(posedge clk); #1;

    @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
